// File: rtl/demux_pkg.sv
// Shared constants and helpers for the parameterized 1-to-N demultiplexer.
// Imported by the one-hot decoder and by the demux top level.
package demux_pkg;

  localparam int DEMUX_DATA_W  = 1;
  localparam int DEMUX_NUM_OUT = 4;

  // A single-lane build still needs a one-bit select port.
  function automatic int sel_width(input int num_out);
    return (num_out > 1) ? $clog2(num_out) : 1;
  endfunction

endpackage : demux_pkg

// File: rtl/onehot_decoder.sv
// Binary select to one-hot lane enable.
// Select values beyond the last lane decode to all zeros.
module onehot_decoder
  import demux_pkg::*;
#(
  parameter int NUM_OUT = DEMUX_NUM_OUT,
  parameter int SEL_W   = sel_width(NUM_OUT)
) (
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] onehot
);

  always_comb begin
    // NOTE: the default comes first so every path assigns onehot and no latch is inferred.
    onehot = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (int'(sel) == k) begin
        onehot[k] = 1'b1;
      end
    end
  end

endmodule : onehot_decoder

// File: rtl/demux_1to4.sv
// Parameterized 1-to-N demultiplexer: I is copied to lane S, all other lanes are zero.
// REG_OUT selects a one-cycle registered output stage or a purely combinational path.
module demux_1to4
  import demux_pkg::*;
#(
  parameter int DATA_W  = DEMUX_DATA_W,
  parameter int NUM_OUT = DEMUX_NUM_OUT,
  parameter int SEL_W   = sel_width(NUM_OUT),
  parameter int REG_OUT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         I,
  input  logic [SEL_W-1:0]          S,
  output logic [NUM_OUT*DATA_W-1:0] Y
);

  logic [NUM_OUT-1:0]        lane_en;
  logic [NUM_OUT*DATA_W-1:0] decoded;

  onehot_decoder #(
    .NUM_OUT(NUM_OUT),
    .SEL_W  (SEL_W)
  ) u_onehot_decoder (
    .sel   (S),
    .onehot(lane_en)
  );

  // Gating with the enable means a deselected lane can never keep stale data.
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
    assign decoded[k*DATA_W +: DATA_W] = {DATA_W{lane_en[k]}} & I;
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [NUM_OUT*DATA_W-1:0] y_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
      if (rst) begin
        y_q <= '0;
      end else begin
        y_q <= decoded;
      end
    end

    assign Y = y_q;
  end else begin : g_comb_out
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign Y              = decoded;
  end

endmodule : demux_1to4

// File: tb/tb_demux_1to4.sv
// Self-checking bench for demux_1to4: registered default, a 3-lane 8-bit variant,
// and a combinational build, all compared against an arithmetic reference model.
module tb_demux_1to4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_i = 1'b0;
  logic [1:0]  a_s = '0;
  logic [7:0]  b_i = '0;
  logic [1:0]  b_s = '0;
  logic        c_i = 1'b0;
  logic [1:0]  c_s = '0;
  logic [3:0]  y_a;
  logic [23:0] y_b;
  logic [3:0]  y_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux_1to4 u_a (
    .clk(clk), .rst(rst), .I(a_i), .S(a_s), .Y(y_a)
  );

  demux_1to4 #(.DATA_W(8), .NUM_OUT(3)) u_b (
    .clk(clk), .rst(rst), .I(b_i), .S(b_s), .Y(y_b)
  );

  demux_1to4 #(.REG_OUT(0)) u_c (
    .clk(clk), .rst(rst), .I(c_i), .S(c_s), .Y(y_c)
  );

  // Reference: data shifted into lane s, or nothing when s names no lane.
  function automatic logic [31:0] ref_y(input int n, input int w,
                                        input logic [31:0] data, input int s);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    if (s < n) return (data & mask) << (s * w);
    return 32'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of stimulus; checks the comb build right away and the
  // registered builds just after the capturing edge.
  task automatic step(input logic r, input logic ai, input logic [1:0] as,
                      input logic [7:0] bi, input logic [1:0] bs);
    logic [31:0] exp_a, exp_b;
    rst = r; a_i = ai; a_s = as; b_i = bi; b_s = bs; c_i = ai; c_s = as;
    #1;
    check("comb_model", 32'(y_c), ref_y(4, 1, 32'(ai), int'(as)));
    exp_a = r ? 32'd0 : ref_y(4, 1, 32'(ai), int'(as));
    exp_b = r ? 32'd0 : ref_y(3, 8, 32'(bi), int'(bs));
    @(posedge clk);
    #1;
    check("reg4_model", 32'(y_a), exp_a);
    check("reg3x8_model", 32'(y_b), exp_b);
    @(negedge clk);
  endtask

  typedef struct {
    logic        r;
    logic        ai;
    logic [1:0]  as;
    logic [7:0]  bi;
    logic [1:0]  bs;
    logic [3:0]  exp_a;
    logic [23:0] exp_b;
  } vec_t;

  vec_t vecs [11];

  initial begin
    // Reset hold, release, back-to-back selects, mid-stream reset pulse.
    vecs[0]  = '{1'b1, 1'b1, 2'd1, 8'hA5, 2'd1, 4'b0000, 24'h000000};
    vecs[1]  = '{1'b1, 1'b1, 2'd1, 8'hA5, 2'd1, 4'b0000, 24'h000000};
    vecs[2]  = '{1'b0, 1'b1, 2'd1, 8'hA5, 2'd3, 4'b0010, 24'h000000};
    vecs[3]  = '{1'b0, 1'b1, 2'd0, 8'hA5, 2'd1, 4'b0001, 24'h00A500};
    vecs[4]  = '{1'b0, 1'b1, 2'd3, 8'h3C, 2'd0, 4'b1000, 24'h00003C};
    vecs[5]  = '{1'b0, 1'b1, 2'd1, 8'h3C, 2'd2, 4'b0010, 24'h3C0000};
    vecs[6]  = '{1'b0, 1'b1, 2'd2, 8'hFF, 2'd3, 4'b0100, 24'h000000};
    vecs[7]  = '{1'b0, 1'b1, 2'd3, 8'h00, 2'd0, 4'b1000, 24'h000000};
    vecs[8]  = '{1'b1, 1'b1, 2'd3, 8'h00, 2'd0, 4'b0000, 24'h000000};
    vecs[9]  = '{1'b0, 1'b1, 2'd3, 8'h00, 2'd0, 4'b1000, 24'h000000};
    vecs[10] = '{1'b0, 1'b1, 2'd3, 8'h00, 2'd0, 4'b1000, 24'h000000};

    for (int v = 0; v < 11; v++) begin
      step(vecs[v].r, vecs[v].ai, vecs[v].as, vecs[v].bi, vecs[v].bs);
      check($sformatf("vec%0d_y4", v), 32'(y_a), 32'(vecs[v].exp_a));
      check($sformatf("vec%0d_y3x8", v), 32'(y_b), 32'(vecs[v].exp_b));
    end

    // Select sweep: I toggles every cycle, S held 10 cycles per lane.
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 10; c++) begin
        step(1'b0, 1'(c % 2), 2'(s), 8'(c * 17), 2'(s));
      end
    end

    // Zero data gives zero on every lane whatever the select.
    for (int s = 0; s < 4; s++) begin
      step(1'b0, 1'b0, 2'(s), 8'h00, 2'(s));
      check("data_zero_y4", 32'(y_a), 32'd0);
      check("data_zero_comb", 32'(y_c), 32'd0);
    end

    // Randomized traffic with occasional reset pulses.
    for (int n = 0; n < 300; n++) begin
      step(1'($urandom_range(0, 15) == 0), 1'($urandom), 2'($urandom),
           8'($urandom), 2'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_demux_1to4
